// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, state encoding and the XY-to-linear address mapping
// used by both the pixel writer and the scan-out side of the background RAM.
package fb_pkg;

    localparam int H_RES     = 160;
    localparam int V_RES     = 120;
    localparam int FB_PIXELS = H_RES * V_RES;
    localparam int ADDR_W    = 15;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fb_state_e;

    // y*160 as (y<<7)+(y<<5) keeps the mapping multiplier-free.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x, input logic [7:0] y);
        logic [ADDR_W-1:0] y_ext;
        logic [ADDR_W-1:0] x_ext;
        y_ext = {{(ADDR_W-8){1'b0}}, y};
        x_ext = {{(ADDR_W-8){1'b0}}, x};
        return (y_ext << 7) + (y_ext << 5) + x_ext;
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational coordinate-to-address conversion with range check; shared with
// read-side blocks that need the same linear layout.
module fb_addr_calc
    import fb_pkg::*;
(
    input  logic [7:0]        x_i,
    input  logic [7:0]        y_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              in_range_o
);

    assign addr_o     = xy_to_addr(x_i, y_i);
    assign in_range_o = (x_i < 8'(H_RES)) && (y_i < 8'(V_RES));

endmodule

// File: rtl/fb_pixel_writer.sv
// Single writer of the 160x120 1-bit background RAM: per-pixel plots with a
// one-cycle latency, plus a full-frame fill sweep.
module fb_pixel_writer
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        x_in,
    input  logic [7:0]        y_in,
    input  logic [11:0]       color_in,
    input  logic              plot_valid,
    output logic              plot_ready,
    input  logic              fill_start,
    input  logic              fill_value,
    output logic              busy,
    output logic              fill_done,
    output logic              drop,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_data,
    output logic              ram_wren
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

    fb_state_e         state_q;
    logic              fill_val_q;
    logic              plot_ready_q;
    logic              busy_q;
    logic              fill_done_q;
    logic              drop_q;
    logic [ADDR_W-1:0] ram_address_q;
    logic              ram_data_q;
    logic              ram_wren_q;

    logic [ADDR_W-1:0] plot_addr;
    logic              plot_in_range;

    fb_addr_calc u_addr_calc (
        .x_i        (x_in),
        .y_i        (y_in),
        .addr_o     (plot_addr),
        .in_range_o (plot_in_range)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            fill_val_q    <= 1'b0;
            plot_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
            fill_done_q   <= 1'b0;
            drop_q        <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= 1'b0;
            ram_wren_q    <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            drop_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    ram_wren_q <= 1'b0;
                    if (fill_start) begin
                        // The first fill write goes out on the same edge that enters FILL.
                        state_q       <= FILL;
                        fill_val_q    <= fill_value;
                        busy_q        <= 1'b1;
                        plot_ready_q  <= 1'b0;
                        ram_wren_q    <= 1'b1;
                        ram_address_q <= '0;
                        ram_data_q    <= fill_value;
                    end else begin
                        plot_ready_q <= 1'b1;
                        if (plot_valid && plot_ready_q) begin
                            if (plot_in_range) begin
                                ram_wren_q    <= 1'b1;
                                ram_address_q <= plot_addr;
                                ram_data_q    <= |color_in;
                            end else begin
                                drop_q <= 1'b1;
                            end
                        end
                    end
                end
                FILL: begin
                    if (ram_address_q == LAST_ADDR) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        plot_ready_q <= 1'b1;
                        fill_done_q  <= 1'b1;
                        ram_wren_q   <= 1'b0;
                    end else begin
                        ram_wren_q    <= 1'b1;
                        ram_address_q <= ram_address_q + ADDR_W'(1);
                        ram_data_q    <= fill_val_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign plot_ready  = plot_ready_q;
    assign busy        = busy_q;
    assign fill_done   = fill_done_q;
    assign drop        = drop_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: expected RAM writes are queued as stimulus
// is driven and popped as the write port fires.
module tb_fb_pixel_writer;

    localparam int NPIX = 160 * 120;

    logic        clk;
    logic        resetn;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [11:0] color_in;
    logic        plot_valid;
    logic        plot_ready;
    logic        fill_start;
    logic        fill_value;
    logic        busy;
    logic        fill_done;
    logic        drop;
    logic [14:0] ram_address;
    logic        ram_data;
    logic        ram_wren;

    typedef struct packed {
        logic [14:0] addr;
        logic        data;
    } wr_t;

    wr_t exp_q[$];
    bit  ram_model [NPIX];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  drop_cnt = 0;
    int  done_cnt = 0;

    fb_pixel_writer dut (
        .clk         (clk),
        .resetn      (resetn),
        .x_in        (x_in),
        .y_in        (y_in),
        .color_in    (color_in),
        .plot_valid  (plot_valid),
        .plot_ready  (plot_ready),
        .fill_start  (fill_start),
        .fill_value  (fill_value),
        .busy        (busy),
        .fill_done   (fill_done),
        .drop        (drop),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic push_exp(input int a, input logic d);
        wr_t w;
        w.addr = 15'(a);
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Write-port monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ram_wren === 1'b1) begin
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 32'(ram_address), 32'(w.addr));
                check("wr_data", 32'(ram_data), 32'(w.data));
            end
            if (int'(ram_address) < NPIX) ram_model[int'(ram_address)] = ram_data;
        end
        if (drop === 1'b1) drop_cnt++;
        if (fill_done === 1'b1) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic plot_once(input int x, input int y, input logic [11:0] c);
        bit inr;
        inr = (x < 160) && (y < 120);
        check("plot_ready_pre", 32'(plot_ready), 32'd1);
        x_in = 8'(x); y_in = 8'(y); color_in = c; plot_valid = 1'b1;
        if (inr) push_exp(y * 160 + x, c != 12'd0);
        tick();
        plot_valid = 1'b0;
        check("plot_wren", 32'(ram_wren), 32'(inr));
        check("plot_drop", 32'(drop), 32'(!inr));
        if (inr) check("plot_addr", 32'(ram_address), 32'(y * 160 + x));
        tick();
        check("drop_single", 32'(drop), 32'd0);
    endtask

    // Waits for fill_done, returning cycles counted from the fill_start edge.
    task automatic wait_fill_done(output int n);
        n = 1;
        while (fill_done !== 1'b1 && n < 20000) begin
            tick();
            n++;
        end
        check("fill_timeout", 32'(n < 20000), 32'd1);
    endtask

    initial begin
        int n;
        int ones;
        int done_snap;
        resetn = 1'b0; x_in = '0; y_in = '0; color_in = '0;
        plot_valid = 1'b0; fill_start = 1'b0; fill_value = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_ready", 32'(plot_ready), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_done", 32'(fill_done), 32'd0);
        resetn = 1'b1;
        tick();
        check("idle_ready", 32'(plot_ready), 32'd1);

        // Corner plots, including exact boundaries
        plot_once(0, 0, 12'hFFF);
        plot_once(159, 119, 12'h000);
        check("addr_hold", 32'(ram_address), 32'd19199);
        check("wren_idle", 32'(ram_wren), 32'd0);
        plot_once(160, 5, 12'h001);
        plot_once(3, 120, 12'h001);
        check("drop_count", 32'(drop_cnt), 32'd2);
        plot_once(159, 0, 12'h800);
        plot_once(0, 119, 12'h010);

        // Back-to-back plots: one write per cycle
        for (int i = 1; i <= 4; i++) begin
            check("b2b_ready", 32'(plot_ready), 32'd1);
            x_in = 8'(i); y_in = 8'd2; color_in = 12'(i); plot_valid = 1'b1;
            push_exp(2 * 160 + i, 1'b1);
            tick();
            check("b2b_wren", 32'(ram_wren), 32'd1);
        end
        plot_valid = 1'b0;
        tick();
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Full fill with ones
        fill_value = 1'b1; fill_start = 1'b1;
        for (int a = 0; a < NPIX; a++) push_exp(a, 1'b1);
        tick();
        fill_start = 1'b0; fill_value = 1'b0;
        check("fill_busy", 32'(busy), 32'd1);
        check("fill_ready", 32'(plot_ready), 32'd0);
        wait_fill_done(n);
        check("fill_len", 32'(n), 32'(NPIX + 1));
        check("fill_busy_end", 32'(busy), 32'd0);
        check("fill_ready_end", 32'(plot_ready), 32'd1);
        check("fill_q_empty", 32'(exp_q.size()), 32'd0);
        ones = 0;
        for (int a = 0; a < NPIX; a++) ones += int'(ram_model[a]);
        check("fill_ones", 32'(ones), 32'(NPIX));
        tick();
        check("fill_done_pulse", 32'(fill_done), 32'd0);
        check("fill_done_cnt", 32'(done_cnt), 32'd1);

        // Fill (zeros) and plot in the same cycle: plot held until fill_done
        fill_start = 1'b1; fill_value = 1'b0;
        x_in = 8'd10; y_in = 8'd10; color_in = 12'h123; plot_valid = 1'b1;
        for (int a = 0; a < NPIX; a++) push_exp(a, 1'b0);
        push_exp(1610, 1'b1);
        tick();
        fill_start = 1'b0;
        check("hold_ready", 32'(plot_ready), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_first_addr", 32'(ram_address), 32'd0);
        wait_fill_done(n);
        tick();
        plot_valid = 1'b0;
        check("held_wren", 32'(ram_wren), 32'd1);
        check("held_addr", 32'(ram_address), 32'd1610);
        tick();
        check("held_q_empty", 32'(exp_q.size()), 32'd0);
        check("held_model", 32'(ram_model[1610]), 32'd1);
        check("held_model0", 32'(ram_model[0]), 32'd0);

        // Reset in the middle of a fill
        fill_start = 1'b1; fill_value = 1'b1;
        for (int a = 0; a < 5000; a++) push_exp(a, 1'b1);
        tick();
        fill_start = 1'b0;
        n = 0;
        while (!(ram_wren === 1'b1 && ram_address == 15'd5000) && n < 10000) begin
            tick();
            n++;
        end
        check("abort_reach", 32'(n < 10000), 32'd1);
        done_snap = done_cnt;
        resetn = 1'b0;
        #1;
        check("abort_wren", 32'(ram_wren), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(plot_ready), 32'd0);
        tick(); tick();
        resetn = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        check("abort_no_done", 32'(done_cnt), 32'(done_snap));
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_ready", 32'(plot_ready), 32'd1);
        check("abort_q_empty", 32'(exp_q.size()), 32'd0);
        plot_once(7, 7, 12'h00F);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        check("final_drops", 32'(drop_cnt), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
